refresh_scheduler: RTL and testbench

- Parametrised SDRAM refresh scheduler in the ECLK domain.
- Generates refresh demand at a fixed ECLK interval and accumulates missed refreshes as a saturating debt, so the CLK-domain SDRAM controller can postpone refresh behind Zorro cycles and then issue back-to-back refreshes.
- Retires debt from a Gray-coded completion count driven by the SDRAM controller, so any number of refreshes completed within one ECLK period is credited.

---
 rtl/refresh_scheduler_pkg.sv | 31 +++
 rtl/refresh_scheduler_if.sv | 22 ++
 rtl/refresh_scheduler_gray_sync.sv | 29 ++
 rtl/refresh_scheduler.sv | 128 ++++++++++++
 tb/tb_refresh_scheduler.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/refresh_scheduler_pkg.sv
// Shared defaults, Gray-code helpers and state encodings for the SDRAM refresh scheduler.
package refresh_scheduler_pkg;

  localparam int REFRESH_INTERVAL = 5;
  localparam int REFRESH_MAX_DEBT = 8;
  localparam int REFRESH_URGENT   = 6;
  localparam int REFRESH_DONE_W   = 4;

  // Widest Gray count the helpers handle; narrower counts are zero-extended.
  localparam int GRAY_MAX_W = 16;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } sched_state_t;

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/refresh_scheduler_if.sv
// Scheduler <-> SDRAM controller signal bundle; the controller is the master.
interface refresh_scheduler_if #(
  parameter int DONE_W = 4,
  parameter int DEBT_W = 4
);
  logic              enable;
  logic [DONE_W-1:0] done_gray;
  logic              refresh_req;
  logic              refresh_urgent;
  logic [DEBT_W-1:0] debt;
  logic              overflow;

  modport master (
    output enable, done_gray,
    input  refresh_req, refresh_urgent, debt, overflow
  );

  modport slave (
    input  enable, done_gray,
    output refresh_req, refresh_urgent, debt, overflow
  );
endinterface

// File: rtl/refresh_scheduler_gray_sync.sv
// Two-flop synchroniser for the CLK-domain Gray completion count, converted to binary in ECLK.
module gray_sync
  import refresh_scheduler_pkg::*;
#(
  parameter int DONE_W = REFRESH_DONE_W
) (
  input  logic              ECLK,
  input  logic              refreshreset,
  input  logic [DONE_W-1:0] done_gray,
  output logic [DONE_W-1:0] done_bin
);

  logic [DONE_W-1:0] sync_p0;
  logic [DONE_W-1:0] sync_p1;

  always_ff @(posedge ECLK or negedge refreshreset) begin
    if (!refreshreset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= done_gray;
      sync_p1 <= sync_p0;
    end
  end

  // Only one bit moves per Gray step, so the settled word is always a valid count.
  assign done_bin = DONE_W'(gray2bin(gray_word_t'(sync_p1)));

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh interval timer plus saturating refresh debt, retired by a synchronised completion count.
module refresh_scheduler
  import refresh_scheduler_pkg::*;
#(
  parameter int INTERVAL     = REFRESH_INTERVAL,
  parameter int MAX_DEBT     = REFRESH_MAX_DEBT,
  parameter int URGENT_LEVEL = REFRESH_URGENT,
  parameter int DONE_W       = REFRESH_DONE_W
) (
  input  logic               ECLK,
  input  logic               refreshreset,
  refresh_scheduler_if.slave bus
);

  localparam int DEBT_W = $clog2(MAX_DEBT + 1);
  localparam int TMR_W  = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int SUM_W  = ((DEBT_W > DONE_W) ? DEBT_W : DONE_W) + 2;

  localparam logic [TMR_W-1:0]        TMR_RELOAD = TMR_W'(INTERVAL - 1);
  localparam logic [DEBT_W-1:0]       DEBT_MAX   = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0]       DEBT_URG   = DEBT_W'(URGENT_LEVEL);
  localparam logic signed [SUM_W-1:0] SUM_MAX    = SUM_W'(MAX_DEBT);

  function automatic logic [DEBT_W-1:0] sat_debt(input logic signed [SUM_W-1:0] v);
    if (v < 0) begin
      return '0;
    end else if (v > SUM_MAX) begin
      return DEBT_MAX;
    end
    return v[DEBT_W-1:0];
  endfunction

  logic [TMR_W-1:0]        timer_q;
  logic                    tick;
  sched_state_t            state_q, state_d;
  logic [1:0]              warm_q, warm_d;
  logic                    credit_en;
  logic [DONE_W-1:0]       done_bin;
  logic [DONE_W-1:0]       last_bin_p1;
  logic [DONE_W-1:0]       delta;
  logic [DONE_W-1:0]       credit;
  logic signed [SUM_W-1:0] sum_p0;
  logic [DEBT_W-1:0]       debt_d;
  logic                    overflow_d;
  logic [DEBT_W-1:0]       debt_p1;
  logic                    req_p1, urgent_p1, overflow_p1;

  gray_sync #(.DONE_W(DONE_W)) u_gray_sync (
    .ECLK         (ECLK),
    .refreshreset (refreshreset),
    .done_gray    (bus.done_gray),
    .done_bin     (done_bin)
  );

  assign tick = bus.enable && (timer_q == '0);

  always_ff @(posedge ECLK or negedge refreshreset) begin
    if (!refreshreset) begin
      timer_q <= TMR_RELOAD;
    end else if (!bus.enable || timer_q == '0) begin
      timer_q <= TMR_RELOAD;
    end else begin
      timer_q <= timer_q - TMR_W'(1);
    end
  end

  always_ff @(posedge ECLK or negedge refreshreset) begin
    if (!refreshreset) begin
      state_q <= WARMUP;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // last_bin must capture a completely refilled synchroniser before credit is
  // taken, so WARMUP spans the two fill edges plus the edge that captures them.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    credit_en = 1'b0;
    case (state_q)
      WARMUP: begin
        if (warm_q == 2'd2) begin
          state_d = RUN;
        end else begin
          warm_d = warm_q + 2'd1;
        end
      end
      RUN:     credit_en = 1'b1;
      default: state_d   = WARMUP;
    endcase
  end

  // Modular subtraction absorbs wrap of the completion count.
  assign delta  = done_bin - last_bin_p1;
  assign credit = credit_en ? delta : '0;

  always_comb begin
    sum_p0     = $signed(SUM_W'(debt_p1)) + $signed(SUM_W'(tick)) - $signed(SUM_W'(credit));
    debt_d     = sat_debt(sum_p0);
    overflow_d = overflow_p1 || (sum_p0 > SUM_MAX);
  end

  // Stage p1: debt and its flags register together from the same next value.
  always_ff @(posedge ECLK or negedge refreshreset) begin
    if (!refreshreset) begin
      debt_p1     <= '0;
      req_p1      <= 1'b0;
      urgent_p1   <= 1'b0;
      overflow_p1 <= 1'b0;
      last_bin_p1 <= '0;
    end else begin
      debt_p1     <= debt_d;
      req_p1      <= (debt_d != '0);
      urgent_p1   <= (debt_d >= DEBT_URG);
      overflow_p1 <= overflow_d;
      last_bin_p1 <= done_bin;
    end
  end

  assign bus.debt           = debt_p1;
  assign bus.refresh_req    = req_p1;
  assign bus.refresh_urgent = urgent_p1;
  assign bus.overflow       = overflow_p1;

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler: per-edge expectations queued as stimulus is applied.
module tb_refresh_scheduler;

  localparam int DONE_W = 4;
  localparam int DEBT_W = 4;

  logic ECLK = 1'b0;
  logic refreshreset = 1'b0;

  refresh_scheduler_if #(.DONE_W(DONE_W), .DEBT_W(DEBT_W)) bus ();

  refresh_scheduler #(
    .INTERVAL     (5),
    .MAX_DEBT     (8),
    .URGENT_LEVEL (6),
    .DONE_W       (DONE_W)
  ) dut (
    .ECLK         (ECLK),
    .refreshreset (refreshreset),
    .bus          (bus)
  );

  always #10 ECLK = ~ECLK;

  typedef struct packed {
    logic [DEBT_W-1:0] debt;
    logic              req;
    logic              urg;
    logic              ovf;
  } exp_t;

  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                edge_n = 0;
  logic              exp_ovf = 1'b0;
  logic [DONE_W-1:0] cnt = '0;

  task automatic check_vec(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_vec({tag, ".debt"}, 8'(bus.debt), 8'(e.debt));
    check_vec({tag, ".refresh_req"}, 8'(bus.refresh_req), 8'(e.req));
    check_vec({tag, ".refresh_urgent"}, 8'(bus.refresh_urgent), 8'(e.urg));
    check_vec({tag, ".overflow"}, 8'(bus.overflow), 8'(e.ovf));
  endtask

  // Queue the expected state after the next edge, then take the edge and compare.
  task automatic step(input int d);
    exp_t e;
    e.debt = DEBT_W'(d);
    e.req  = (d != 0);
    e.urg  = (d >= 6);
    e.ovf  = exp_ovf;
    sb.push_back(e);
    @(posedge ECLK);
    #1;
    edge_n++;
    e = sb.pop_front();
    check_outputs($sformatf("edge%0d", edge_n), e);
  endtask

  task automatic hold(input int n, input int d);
    for (int i = 0; i < n; i++) step(d);
  endtask

  // Completed refreshes arrive one Gray step at a time, all inside one ECLK period.
  task automatic advance(input int k);
    for (int i = 0; i < k; i++) begin
      cnt = cnt + 1'b1;
      bus.done_gray = cnt ^ (cnt >> 1);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t zero;
    zero = '0;
    bus.enable    = 1'b1;
    bus.done_gray = '0;
    refreshreset  = 1'b0;

    repeat (2) @(posedge ECLK);
    #1;
    check_outputs("reset", zero);
    refreshreset = 1'b1;

    // Debt builds one per five edges, saturates at 8, overflow on edge 45.
    for (int k = 1; k <= 45; k++) begin
      exp_ovf = (k >= 45);
      step((k / 5 > 8) ? 8 : k / 5);
    end

    advance(8);
    hold(2, 8); hold(2, 0); hold(5, 1); hold(5, 2); step(3);
    advance(3);
    hold(2, 3); hold(2, 0); step(1);
    advance(2);
    hold(2, 1); hold(2, 0); hold(5, 1); hold(3, 2);
    advance(1);
    hold(7, 2); step(3);
    advance(1);
    hold(2, 3); hold(2, 2); hold(5, 3); step(4);
    advance(1);
    hold(2, 4); hold(2, 3); step(4);

    // Asynchronous reset between edges clears everything at once.
    #4;
    refreshreset = 1'b0;
    #1;
    check_outputs("async_reset", zero);

    bus.enable    = 1'b0;
    cnt           = 4'd5;
    bus.done_gray = cnt ^ (cnt >> 1);
    exp_ovf       = 1'b0;
    repeat (2) @(posedge ECLK);
    #1;
    refreshreset = 1'b1;
    edge_n = 100;
    hold(10, 0);
    bus.enable = 1'b1;
    hold(4, 0);
    step(1);
    hold(4, 1);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
